// File: rtl/rotary_pkg.sv
// rotary_pkg: shared types for the rotary parameter controller
package rotary_pkg;
  typedef enum logic {ST_BROWSE, ST_EDIT} state_t;
  typedef logic [7:0] param_t;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registers a level once and flags its rising edge
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q, prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      d_q <= d;
      prev_q <= d_q;
    end
  end
  assign rise = d_q & ~prev_q;
endmodule

// File: rtl/rotary_param_ctrl.sv
// rotary_param_ctrl: browse/edit UI over a bank of 8-bit parameters driven by encoder steps
module rotary_param_ctrl
  import rotary_pkg::*;
#(
  parameter int     NUM_PARAMS     = 4,
  parameter param_t RESET_VAL      = 8'd0,
  parameter param_t MAX_VAL        = 8'd255,
  parameter int     FAST_WINDOW    = 2_500_000,
  parameter param_t FAST_STEP      = 8'd8,
  parameter int     TIMEOUT_CYCLES = 250_000_000,
  localparam int    SEL_W          = $clog2(NUM_PARAMS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rot_cw,
  input  logic                            rot_ccw,
  input  logic                            btn,
  output logic [SEL_W-1:0]                sel,
  output logic                            editing,
  output param_t [NUM_PARAMS-1:0]         params,
  output logic                            changed,
  output logic [SEL_W-1:0]                changed_idx
);
  localparam int GW = $clog2(FAST_WINDOW + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_PARAMS - 1);
  logic cw_ev, ccw_ev, btn_ev, rot_ok, any_ev;
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, changed_idx_q, changed_idx_d;
  param_t [NUM_PARAMS-1:0] params_q, params_d;
  logic editing_q, changed_q, changed_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] idle_q, idle_d;
  param_t cur, step, nxt;
  logic [8:0] up, dn;
  rise_detect u_cw  (.clk(clk), .rst(rst), .d(rot_cw),  .rise(cw_ev));
  rise_detect u_ccw (.clk(clk), .rst(rst), .d(rot_ccw), .rise(ccw_ev));
  rise_detect u_btn (.clk(clk), .rst(rst), .d(btn),     .rise(btn_ev));
  assign rot_ok = cw_ev ^ ccw_ev;
  assign any_ev = cw_ev | ccw_ev | btn_ev;
  assign cur  = params_q[sel_q];
  assign step = (gap_q < GW'(FAST_WINDOW)) ? FAST_STEP : 8'd1;
  assign up   = {1'b0, cur} + {1'b0, step};
  assign dn   = {1'b0, cur} - {1'b0, step};
  // borrow into bit 8 means the decrement went below zero
  assign nxt  = cw_ev ? ((up > {1'b0, MAX_VAL}) ? MAX_VAL : up[7:0]) : (dn[8] ? 8'd0 : dn[7:0]);
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    params_d = params_q;
    changed_d = 1'b0;
    changed_idx_d = changed_idx_q;
    gap_d = (gap_q == GW'(FAST_WINDOW)) ? gap_q : gap_q + 1'b1;
    idle_d = idle_q;
    if (state_q == ST_BROWSE) begin
      if (rot_ok) sel_d = cw_ev ? ((sel_q == LAST) ? '0 : sel_q + 1'b1) : ((sel_q == '0) ? LAST : sel_q - 1'b1);
      if (btn_ev) begin
        state_d = ST_EDIT;
        idle_d = '0;
      end
    end else begin
      if (rot_ok) begin
        gap_d = '0;
        params_d[sel_q] = nxt;
        changed_d = nxt != cur;
        changed_idx_d = sel_q;
      end
      if (any_ev) begin
        idle_d = '0;
        if (btn_ev) state_d = ST_BROWSE;
      end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) state_d = ST_BROWSE;
      else idle_d = idle_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BROWSE;
      sel_q <= '0;
      editing_q <= 1'b0;
      params_q <= {NUM_PARAMS{RESET_VAL}};
      changed_q <= 1'b0;
      changed_idx_q <= '0;
      gap_q <= GW'(FAST_WINDOW);
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      editing_q <= state_d == ST_EDIT;
      params_q <= params_d;
      changed_q <= changed_d;
      changed_idx_q <= changed_idx_d;
      gap_q <= gap_d;
      idle_q <= idle_d;
    end
  end
  assign sel = sel_q;
  assign editing = editing_q;
  assign params = params_q;
  assign changed = changed_q;
  assign changed_idx = changed_idx_q;
endmodule

// File: tb/tb_rotary_param_ctrl.sv
// tb_rotary_param_ctrl: random and directed encoder stimulus against a time-based reference model
module tb_rotary_param_ctrl;
  localparam int N = 4, FW = 100, FS = 8, TO = 50, MAXV = 250;
  logic clk = 1'b0, rst = 1'b1, rot_cw = 1'b0, rot_ccw = 1'b0, btn = 1'b0;
  logic [1:0] sel, changed_idx;
  logic editing, changed;
  logic [N-1:0][7:0] params;
  int checks = 0, errors = 0;
  longint now = 0, last_step, last_act;
  bit m_edit, m_chg, p_cw, p_ccw, p_btn, l_cw, l_ccw, l_btn;
  int m_sel, m_idx;
  int vals[N];
  always #5 clk = ~clk;
  rotary_param_ctrl #(
    .NUM_PARAMS(N), .RESET_VAL(8'd0), .MAX_VAL(8'(MAXV)), .FAST_WINDOW(FW),
    .FAST_STEP(8'(FS)), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rot_cw(rot_cw), .rot_ccw(rot_ccw), .btn(btn),
    .sel(sel), .editing(editing), .params(params), .changed(changed), .changed_idx(changed_idx)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, now, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_edit = 0; m_sel = 0; m_chg = 0; m_idx = 0;
    foreach (vals[i]) vals[i] = 0;
    last_step = -1_000_000; last_act = 0;
    {p_cw, p_ccw, p_btn, l_cw, l_ccw, l_btn} = '0;
  endtask
  // apply the events whose input edge was seen in the previous cycle
  task automatic model_edge();
    int st, nv;
    m_chg = 0;
    if (!m_edit) begin
      if (p_cw ^ p_ccw) m_sel = p_cw ? (m_sel + 1) % N : (m_sel + N - 1) % N;
      if (p_btn) begin m_edit = 1; last_act = now; end
    end else begin
      if (p_cw ^ p_ccw) begin
        st = (now - last_step <= FW) ? FS : 1;
        last_step = now;
        nv = p_cw ? vals[m_sel] + st : vals[m_sel] - st;
        if (nv > MAXV) nv = MAXV;
        if (nv < 0) nv = 0;
        if (nv != vals[m_sel]) begin m_chg = 1; m_idx = m_sel; vals[m_sel] = nv; end
      end
      if (p_cw | p_ccw | p_btn) begin
        last_act = now;
        if (p_btn) m_edit = 0;
      end else if (now - last_act >= TO) m_edit = 0;
    end
  endtask
  task automatic tick(input bit cw, input bit ccw, input bit b, input bit r);
    rot_cw = cw; rot_ccw = ccw; btn = b; rst = r;
    @(posedge clk);
    now++;
    if (r) model_reset();
    else begin
      model_edge();
      p_cw = cw & ~l_cw; p_ccw = ccw & ~l_ccw; p_btn = b & ~l_btn;
      l_cw = cw; l_ccw = ccw; l_btn = b;
    end
    @(negedge clk);
    check("sel", 32'(sel), 32'(m_sel));
    check("editing", 32'(editing), 32'(m_edit));
    check("changed", 32'(changed), 32'(m_chg));
    if (m_chg) check("changed_idx", 32'(changed_idx), 32'(m_idx));
    for (int i = 0; i < N; i++) check($sformatf("params[%0d]", i), 32'(params[i]), 32'(vals[i]));
  endtask
  task automatic pulse(input bit cw, input bit ccw, input bit b, input int gap);
    tick(cw, ccw, b, 0);
    repeat (gap) tick(0, 0, 0, 0);
  endtask
  initial begin
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    repeat (5) pulse(1, 0, 0, 3);
    pulse(0, 0, 1, 3);
    repeat (3) pulse(1, 0, 0, 30);
    repeat (40) pulse(1, 0, 0, 4);
    pulse(1, 1, 0, 4);
    repeat (40) pulse(0, 1, 0, 4);
    pulse(0, 0, 1, 3);
    pulse(0, 0, 1, 70);
    pulse(0, 0, 1, 3);
    pulse(1, 0, 0, 3);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    repeat (1500) begin
      int a, g;
      a = $urandom_range(0, 99);
      g = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 130) : $urandom_range(1, 12);
      if (a < 42) pulse(1, 0, 0, g);
      else if (a < 72) pulse(0, 1, 0, g);
      else if (a < 80) pulse(0, 0, 1, g);
      else if (a < 84) pulse(1, 1, 0, g);
      else if (a < 86) pulse(1, 0, 1, g);
      else pulse(0, 0, 0, g);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
